mmu_tlb: RTL and testbench
==========================

// Module: mmu_tlb
// PURPOSE
//   Clocked, parametrised successor to the combinational mmu: translates CPU page numbers to physical pages.
//   Sits between the 68k bus interface and the external page-table RAM.
//   Adds a fully-associative translation cache (TLB), a req/ready handshake, a table-RAM req/ack fetch, and page-fault reporting.
//   Supervisor accesses use the fixed board map; user accesses go through the TLB and the page table.
// PARAMETERS
//   VA_PAGE_BITS  12  CPU page-number width (addr_in = A[23:12]); the supervisor map requires 12
//   TASK_BITS     4   user task id width; the page-table index is {task, page}
//   PA_PAGE_BITS  16  physical page-number width (addr_out = PA[27:12]); the supervisor map requires >=16
//   TLB_ENTRIES   4   number of TLB entries; power of 2, >=2
// PORTS
//   clk                 in   1               system clock
//   rst_n               in   1               asynchronous active-low reset
//   req                 in   1               translation request; held until the req/ready handshake completes
//   addr_in             in   VA_PAGE_BITS    virtual page number
//   fc                  in   3               68k function code; fc[2]=1 selects supervisor
//   rw                  in   1               1 = read, 0 = write
//   user_map            in   TASK_BITS       current user task id
//   supervisor_map_1    in   8               page select for the 0xAxx window
//   supervisor_map_2    in   8               page select for the 0xBxx window
//   flush               in   1               invalidate all TLB entries
//   table_ram_req       out  1               page-table read request
//   table_ram_addr      out  TASK_BITS+VA_PAGE_BITS  {user_map, addr_in}, registered
//   table_ram_ack       in   1               table data valid this cycle
//   table_ram_data      in   PA_PAGE_BITS+2  entry: [PA+1]=valid, [PA]=write-protect, [PA-1:0]=page
//   addr_out            out  PA_PAGE_BITS    physical page; valid while ready=1
//   ready               out  1               one-cycle translation-complete strobe
//   fault               out  1               qualifies ready: no valid translation; addr_out=0
// BEHAVIOUR
// - Reset: state IDLE; all TLB valid bits clear; victim pointer 0; every output 0.
//   rst_n low mid-fetch drops table_ram_req immediately.
// - States: IDLE, FETCH, DONE, RELEASE.
// - IDLE, req=1, fc[2]=1: decode the supervisor map; go to DONE (ready 1 cycle after req).
//   Map: 000-3FF->8000|va[9:0]; 400-7FF->4000|va[9:0]; C00-FFF->3000|va[11:0];
//   800-8FF->0300|va[7:0]; 900-97F->0100|va[6:0]; 980-9FF->0200|va[6:0];
//   A00-AFF->{sel1,va[7:0]}; B00-BFF->{sel2,va[7:0]}; result zero-extended to PA_PAGE_BITS.
// - IDLE, req=1, fc[2]=0: compare tag {user_map, addr_in} against all valid entries in the same cycle.
//   Hit -> DONE (1-cycle latency).
//   Miss -> FETCH: assert table_ram_req and latch table_ram_addr.
// - FETCH: hold table_ram_req and table_ram_addr stable until table_ram_ack; no timeout.
//   On ack: capture data, drop req, go to DONE.
//   Miss latency = ack cycle + 1.
//   If the entry's valid bit is set: write it at the victim pointer; the pointer increments mod TLB_ENTRIES (round-robin).
//   If the valid bit is clear: no fill; fault=1 in DONE.
// - DONE: ready=1 with addr_out/fault for exactly one cycle, then RELEASE.
// - RELEASE: wait until req=0, then IDLE. A held req never produces a second translation.
// - Outputs outside DONE: ready=0, fault=0, addr_out held at its last value.
// - flush: all valid bits clear next edge, from any state.
//   If flush and a fill land on the same edge, flush wins: no entry is written, but the response is still delivered.
//   An identical tag is never held in two entries.
// - user_map changes need no flush, because entries are tagged by task.
// CONFIGURATION
// - MMU_TLB_WP_EN defined:
//   - The write-protect bit is stored per entry.
//   - A user write (rw=0) to a protected page gives ready=1 with fault=1 and addr_out=0, on a hit or after a fill; the entry stays cached.
//   - Reads from the page proceed normally.
// - MMU_TLB_WP_EN undefined: bit [PA] is ignored and not stored; rw is unused; writes never fault.
// TESTING
// - Reset: rst_n=0 mid-FETCH -> table_ram_req, ready, fault, addr_out all 0 at once.
//   After release, the first user access misses.
// - Supervisor: fc=101, addr_in=980 -> ready next cycle, addr_out=0200, no table_ram_req.
//   addr_in=A00, sel1=FF -> FF00; addr_in=C01 -> 3C01.
// - User miss then hit: user_map=1, addr_in=002, ack 3 cycles later with data {1,0,1234}.
//   -> table_ram_addr=1002, then ready with addr_out=1234.
//   Repeat the access -> ready 1 cycle after req, table_ram_req stays 0.
// - Replacement (TLB_ENTRIES=4): fill pages 1..5, then access page 1 -> miss, table_ram_req=1.
//   Access page 2 -> also miss, since it was evicted by the refill of page 1.
// - Fault: entry valid=0 -> ready=1, fault=1, addr_out=0; repeating the access re-fetches.
//   With MMU_TLB_WP_EN, entry {1,1,00AB}: rw=0 -> fault=1; rw=1 -> addr_out=00AB, fault=0.
// - Flush during FETCH, asserted on the ack cycle -> response delivered (addr_out correct).
//   The next access to the same page misses; holding req 5 cycles yields one ready pulse.

Source files
------------

// File: rtl/mmu_tlb.sv
// mmu_tlb: clocked page translator with a fully-associative TLB.
// Supervisor accesses decode a fixed board map; user accesses hit the TLB or
// fetch an entry from the external page-table RAM over a req/ack handshake.
// Optional feature macro: MMU_TLB_WP_EN (per-entry write-protect faults).
module mmu_tlb #(
  parameter int unsigned VA_PAGE_BITS = 12,
  parameter int unsigned TASK_BITS    = 4,
  parameter int unsigned PA_PAGE_BITS = 16,
  parameter int unsigned TLB_ENTRIES  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req,
  input  logic [VA_PAGE_BITS-1:0]           addr_in,
  input  logic [2:0]                        fc,
  input  logic                              rw,
  input  logic [TASK_BITS-1:0]              user_map,
  input  logic [7:0]                        supervisor_map_1,
  input  logic [7:0]                        supervisor_map_2,
  input  logic                              flush,
  output logic                              table_ram_req,
  output logic [TASK_BITS+VA_PAGE_BITS-1:0] table_ram_addr,
  input  logic                              table_ram_ack,
  input  logic [PA_PAGE_BITS+1:0]           table_ram_data,
  output logic [PA_PAGE_BITS-1:0]           addr_out,
  output logic                              ready,
  output logic                              fault
);

  localparam int unsigned TAG_BITS = TASK_BITS + VA_PAGE_BITS;
  localparam int unsigned IDX_BITS = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE, RELEASE} state_t;

  state_t                  state;
  logic [TLB_ENTRIES-1:0]  ent_valid;
  logic [TAG_BITS-1:0]     ent_tag  [TLB_ENTRIES];
  logic [PA_PAGE_BITS-1:0] ent_page [TLB_ENTRIES];
  logic [IDX_BITS-1:0]     victim;

  logic [TAG_BITS-1:0]     tag_c;
  logic                    hit_c;
  logic [PA_PAGE_BITS-1:0] hit_page_c;
  logic                    hit_wp_fault_c;
  logic                    fill_wp_fault_c;
  logic                    fill_c;
  logic                    entry_valid_c;
  logic                    unused_bits;

  assign unused_bits = ^fc[1:0];

  // Fixed supervisor board map, zero-extended to the physical page width.
  function automatic logic [PA_PAGE_BITS-1:0] sup_decode(
    input logic [11:0] va,
    input logic [7:0]  sel1,
    input logic [7:0]  sel2
  );
    logic [15:0] pa;
    pa = 16'h0000;
    case (va[11:10])
      2'b00: pa = {6'b100000, va[9:0]};
      2'b01: pa = {6'b010000, va[9:0]};
      2'b11: pa = {4'h3, va};
      default: begin
        case (va[9:8])
          2'b00: pa = {8'h03, va[7:0]};
          2'b01: pa = va[7] ? {9'b000000100, va[6:0]} : {9'b000000010, va[6:0]};
          2'b10: pa = {sel1, va[7:0]};
          default: pa = {sel2, va[7:0]};
        endcase
      end
    endcase
    return PA_PAGE_BITS'(pa);
  endfunction

`ifdef MMU_TLB_WP_EN
  logic ent_wp [TLB_ENTRIES];
  logic rw_q;
  logic hit_wp_c;
`endif

  assign tag_c         = {user_map, addr_in};
  assign entry_valid_c = table_ram_data[PA_PAGE_BITS+1];
  assign fill_c        = (state == FETCH) && table_ram_ack && entry_valid_c && !flush;

  // Parallel tag compare across all valid entries.
  always_comb begin
    hit_c      = 1'b0;
    hit_page_c = '0;
`ifdef MMU_TLB_WP_EN
    hit_wp_c   = 1'b0;
`endif
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      if (ent_valid[i] && (ent_tag[i] == tag_c)) begin
        hit_c      = 1'b1;
        hit_page_c = ent_page[i];
`ifdef MMU_TLB_WP_EN
        hit_wp_c   = ent_wp[i];
`endif
      end
    end
  end

`ifdef MMU_TLB_WP_EN
  assign hit_wp_fault_c  = hit_wp_c & ~rw;
  assign fill_wp_fault_c = table_ram_data[PA_PAGE_BITS] & ~rw_q;

  // Access direction captured at the miss, used when the entry returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q <= 1'b1;
    end else if (state == IDLE && req) begin
      rw_q <= rw;
    end
  end
`else
  logic unused_wp;
  assign unused_wp       = rw ^ table_ram_data[PA_PAGE_BITS];
  assign hit_wp_fault_c  = 1'b0;
  assign fill_wp_fault_c = 1'b0;
`endif

  // TLB payload storage; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      ent_tag[victim]  <= table_ram_addr;
      ent_page[victim] <= table_ram_data[PA_PAGE_BITS-1:0];
`ifdef MMU_TLB_WP_EN
      ent_wp[victim]   <= table_ram_data[PA_PAGE_BITS];
`endif
    end
  end

  // Control FSM, valid bits, victim pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ent_valid      <= '0;
      victim         <= '0;
      table_ram_req  <= 1'b0;
      table_ram_addr <= '0;
      addr_out       <= '0;
      ready          <= 1'b0;
      fault          <= 1'b0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      if (flush) begin
        ent_valid <= '0;
      end
      case (state)
        IDLE: begin
          if (req) begin
            if (fc[2]) begin
              addr_out <= sup_decode(12'(addr_in), supervisor_map_1, supervisor_map_2);
              ready    <= 1'b1;
              state    <= DONE;
            end else if (hit_c) begin
              ready    <= 1'b1;
              state    <= DONE;
              if (hit_wp_fault_c) begin
                fault    <= 1'b1;
                addr_out <= '0;
              end else begin
                addr_out <= hit_page_c;
              end
            end else begin
              table_ram_req  <= 1'b1;
              table_ram_addr <= tag_c;
              state          <= FETCH;
            end
          end
        end
        FETCH: begin
          if (table_ram_ack) begin
            table_ram_req <= 1'b0;
            ready         <= 1'b1;
            state         <= DONE;
            if (!entry_valid_c || fill_wp_fault_c) begin
              fault    <= 1'b1;
              addr_out <= '0;
            end else begin
              addr_out <= table_ram_data[PA_PAGE_BITS-1:0];
            end
            if (fill_c) begin
              ent_valid[victim] <= 1'b1;
              victim            <= victim + IDX_BITS'(1);
            end
          end
        end
        DONE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (!req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: scoreboard bench for mmu_tlb (default build; honours MMU_TLB_WP_EN).
module tb_mmu_tlb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [11:0] addr_in;
  logic [2:0]  fc;
  logic        rw;
  logic [3:0]  user_map;
  logic [7:0]  sel1;
  logic [7:0]  sel2;
  logic        flush;
  logic        table_ram_req;
  logic [15:0] table_ram_addr;
  logic        table_ram_ack;
  logic [17:0] table_ram_data;
  logic [15:0] addr_out;
  logic        ready;
  logic        fault;

  typedef struct packed {
    logic [15:0] addr;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  mmu_tlb dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .addr_in          (addr_in),
    .fc               (fc),
    .rw               (rw),
    .user_map         (user_map),
    .supervisor_map_1 (sel1),
    .supervisor_map_2 (sel2),
    .flush            (flush),
    .table_ram_req    (table_ram_req),
    .table_ram_addr   (table_ram_addr),
    .table_ram_ack    (table_ram_ack),
    .table_ram_data   (table_ram_data),
    .addr_out         (addr_out),
    .ready            (ready),
    .fault            (fault)
  );

  always #5 clk = ~clk;

  // Page-table contents seen by the bench's table RAM.
  function automatic logic [17:0] pt_entry(input logic [15:0] tag);
    case (tag)
      16'h1002: return {2'b10, 16'h1234};
      16'h40F0: return 18'h0;
      16'h60AB: return {2'b11, 16'h00AB};
      default:  return {2'b10, tag ^ 16'hA5A5};
    endcase
  endfunction

  // Reference supervisor map written as address ranges.
  function automatic logic [15:0] sup_ref(input logic [11:0] va);
    logic [15:0] v;
    v = {4'h0, va};
    if (va <= 12'h3FF)      return 16'h8000 | (v & 16'h03FF);
    else if (va <= 12'h7FF) return 16'h4000 | (v & 16'h03FF);
    else if (va <= 12'h8FF) return 16'h0300 | (v & 16'h00FF);
    else if (va <= 12'h97F) return 16'h0100 | (v & 16'h007F);
    else if (va <= 12'h9FF) return 16'h0200 | (v & 16'h007F);
    else if (va <= 12'hAFF) return {sel1, va[7:0]};
    else if (va <= 12'hBFF) return {sel2, va[7:0]};
    else                    return 16'h3000 | v;
  endfunction

  // One translation: push expectation, drive req, serve the table RAM, compare.
  task automatic access(input bit sup, input logic [3:0] tsk, input logic [11:0] page,
                        input logic rw_i, input bit exp_miss, input int delay,
                        input bit flush_ack, input int hold, input string nm);
    exp_t        e;
    exp_t        got_e;
    logic [17:0] d;
    logic [15:0] tag;
    int          cyc;
    int          reqcyc;
    int          extra;
    bit          got;
    bit          saw_req;
    tag = {tsk, page};
    d   = pt_entry(tag);
    if (sup)        e = '{addr: sup_ref(page), flt: 1'b0};
    else if (!d[17]) e = '{addr: 16'h0, flt: 1'b1};
`ifdef MMU_TLB_WP_EN
    else if (d[16] && !rw_i) e = '{addr: 16'h0, flt: 1'b1};
`endif
    else            e = '{addr: d[15:0], flt: 1'b0};
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; fc = sup ? 3'b101 : 3'b001; addr_in = page; user_map = tsk; rw = rw_i;
    cyc = 0; reqcyc = 0; got = 0; saw_req = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      table_ram_ack = 1'b0;
      flush = 1'b0;
      if (ready) begin
        got = 1;
      end else if (table_ram_req) begin
        if (!saw_req) begin
          n_vec++;
          if (table_ram_addr !== tag) begin
            n_bad++;
            $display("FAIL %s table_ram_addr got %h want %h", nm, table_ram_addr, tag);
          end
        end
        saw_req = 1;
        reqcyc++;
        if (reqcyc == delay) begin
          table_ram_ack = 1'b1; table_ram_data = d; flush = flush_ack;
        end
      end
    end
    table_ram_ack = 1'b0;
    flush = 1'b0;
    n_vec++;
    if (saw_req !== exp_miss) begin
      n_bad++;
      $display("FAIL %s table_ram_req seen %0d want %0d", nm, saw_req, exp_miss);
    end
    got_e = sb.pop_front();
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout waiting for ready", nm);
    end else begin
      if (addr_out !== got_e.addr || fault !== got_e.flt) begin
        n_bad++;
        $display("FAIL %s result got %h/%b want %h/%b", nm, addr_out, fault, got_e.addr, got_e.flt);
      end
      n_vec++;
      if (cyc != (exp_miss ? delay + 1 : 1)) begin
        n_bad++;
        $display("FAIL %s latency got %0d want %0d", nm, cyc, exp_miss ? delay + 1 : 1);
      end
      n_vec++;
      if (table_ram_req !== 1'b0) begin
        n_bad++;
        $display("FAIL %s table_ram_req at ready got %b want 0", nm, table_ram_req);
      end
    end
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready) extra++;
    end
    req = 1'b0;
    @(negedge clk);
    if (ready) extra++;
    @(negedge clk);
    if (ready) extra++;
    n_vec++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL %s extra ready pulses got %0d want 0", nm, extra);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; addr_in = '0; fc = 3'b001; rw = 1'b1; user_map = '0;
    sel1 = 8'h00; sel2 = 8'h00; flush = 1'b0; table_ram_ack = 1'b0; table_ram_data = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({table_ram_req, ready, fault, addr_out, table_ram_addr} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset outputs got req=%b rdy=%b flt=%b out=%h ta=%h want all 0",
               table_ram_req, ready, fault, addr_out, table_ram_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_supervisor();
    sel1 = 8'hFF; sel2 = 8'h5C;
    access(1, 4'h0, 12'h980, 1'b1, 0, 0, 0, 0, "sup_980");
    access(1, 4'h0, 12'hA00, 1'b1, 0, 0, 0, 0, "sup_A00");
    access(1, 4'h0, 12'hC01, 1'b0, 0, 0, 0, 0, "sup_C01");
    access(1, 4'h0, 12'h000, 1'b1, 0, 0, 0, 0, "sup_000");
    access(1, 4'h0, 12'h7FF, 1'b1, 0, 0, 0, 0, "sup_7FF");
    access(1, 4'h0, 12'h8AB, 1'b1, 0, 0, 0, 0, "sup_8AB");
    access(1, 4'h0, 12'h923, 1'b1, 0, 0, 0, 0, "sup_923");
    access(1, 4'h0, 12'hB12, 1'b1, 0, 0, 0, 0, "sup_B12");
  endtask

  task automatic test_miss_hit();
    access(0, 4'h1, 12'h002, 1'b1, 1, 3, 0, 0, "user_miss");
    access(0, 4'h1, 12'h002, 1'b1, 0, 0, 0, 0, "user_hit");
    access(0, 4'h5, 12'h002, 1'b1, 1, 1, 0, 0, "other_task_miss");
    access(0, 4'h1, 12'h002, 1'b0, 0, 0, 0, 0, "task1_still_hit");
  endtask

  task automatic test_replacement();
    do_flush();
    for (int p = 1; p <= 5; p++) access(0, 4'h2, 12'(p), 1'b1, 1, 1, 0, 0, "repl_fill");
    access(0, 4'h2, 12'h001, 1'b1, 1, 2, 0, 0, "repl_page1_miss");
    access(0, 4'h2, 12'h002, 1'b1, 1, 1, 0, 0, "repl_page2_miss");
    access(0, 4'h2, 12'h004, 1'b1, 0, 0, 0, 0, "repl_page4_hit");
  endtask

  task automatic test_fault();
    access(0, 4'h4, 12'h0F0, 1'b1, 1, 2, 0, 0, "fault_invalid");
    access(0, 4'h4, 12'h0F0, 1'b1, 1, 1, 0, 0, "fault_refetch");
  endtask

  task automatic test_wp();
    access(0, 4'h6, 12'h0AB, 1'b0, 1, 1, 0, 0, "wp_write_fill");
    access(0, 4'h6, 12'h0AB, 1'b1, 0, 0, 0, 0, "wp_read_hit");
    access(0, 4'h6, 12'h0AB, 1'b0, 0, 0, 0, 0, "wp_write_hit");
  endtask

  task automatic test_flush();
    access(0, 4'h7, 12'h010, 1'b1, 1, 2, 1, 0, "flush_on_ack");
    access(0, 4'h7, 12'h010, 1'b1, 1, 1, 0, 5, "flush_refetch_hold");
    access(0, 4'h7, 12'h010, 1'b1, 0, 0, 0, 5, "hit_hold");
  endtask

  task automatic test_reset_mid_fetch();
    int  n;
    bit  seen;
    access(0, 4'h1, 12'h002, 1'b1, 1, 1, 0, 0, "prefill");
    @(negedge clk);
    req = 1'b1; fc = 3'b001; user_map = 4'h3; addr_in = 12'h077;
    seen = 0; n = 0;
    while (!seen && n < 5) begin
      @(negedge clk);
      n++;
      if (table_ram_req) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL mid_fetch table_ram_req got 0 want 1");
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({table_ram_req, ready, fault, addr_out} !== 19'h0) begin
      n_bad++;
      $display("FAIL async_reset outputs got req=%b rdy=%b flt=%b out=%h want all 0",
               table_ram_req, ready, fault, addr_out);
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(0, 4'h1, 12'h002, 1'b1, 1, 2, 0, 0, "post_reset_miss");
  endtask

  initial begin
    test_reset();
    test_supervisor();
    test_miss_hit();
    test_replacement();
    test_fault();
    test_wp();
    test_flush();
    test_reset_mid_fetch();
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
